uart_mem_bridge: RTL and testbench
==================================

UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 48: memory word width in bits; multiple of 8; WB = DATA_W/8 bytes per word.
REQ-002 SHALL have parameter ADDR_W, default 23: word address width; AB = ceil(ADDR_W/8) address bytes.
REQ-003 SHALL have parameter CNT_W, default 9: burst count width; CB = ceil(CNT_W/8) count bytes.
REQ-004 SHALL have parameter DEPTH, default 16: internal word FIFO depth (power of 2); maximum burst length.
REQ-005 SHALL have parameter TIMEOUT, default 100000: inter-byte idle cycles before an open frame is aborted; 0 disables the timeout.
REQ-006 Ports; one clock; reset is asynchronous and active-high:
 clk  in  1  system clock (100 MHz domain)
 rst  in  1  asynchronous reset, active-high
 din  in  8  byte from UART receiver
 din_vld  in  1  din valid, single-cycle pulse
 wr_req  out  1  write burst request pulse to memory controller
 rd_req  out  1  read burst request pulse to memory controller
 wr_cnt  out  CNT_W  burst word count (read and write)
 wr_addr  out  ADDR_W  burst start address (read and write)
 wr_data  out  DATA_W  FIFO head word (show-ahead)
 wr_data_rd  in  1  controller pops one write word this cycle
 wr_done  in  1  controller write burst complete pulse
 rd_data  in  DATA_W  read word from controller
 rd_vld  in  1  rd_data valid
 rdy  in  1  UART transmitter idle
 dout  out  8  byte to UART transmitter
 dout_vld  out  1  dout valid pulse
 busy  out  1  high in every state except IDLE

Function
REQ-007 Frame format SHALL be: command byte (0xA5 write, 0x5A read), AB address bytes MSB first, CB count bytes MSB first, then for writes count*WB data bytes (word MSB byte first).
REQ-008 FSM states SHALL be IDLE, ADDR, CNT, WDATA, WREQ, WWAIT, RREQ, RDRAIN, ACK.
REQ-009 IDLE: 0xA5/0x5A SHALL move to ADDR; any other byte SHALL be discarded and IDLE held.
REQ-010 ADDR -> CNT after AB bytes; address truncated to ADDR_W LSBs.
REQ-011 CNT: after CB bytes, count 0 or count > DEPTH SHALL abort to IDLE with no request; else write -> WDATA, read -> RREQ.
REQ-012 WDATA SHALL pack WB bytes per word and push each completed word into the FIFO; after count words -> WREQ.
REQ-013 WREQ SHALL assert wr_req for exactly one cycle with wr_addr/wr_cnt stable, then -> WWAIT; wr_addr/wr_cnt SHALL hold until the next frame.
REQ-014 WWAIT: wr_data SHALL present the FIFO head; wr_data_rd SHALL pop it; on wr_done -> ACK (macro set) else IDLE.
REQ-015 RREQ SHALL pulse rd_req one cycle, then -> RDRAIN; each rd_vld SHALL push rd_data into the FIFO.
REQ-016 RDRAIN SHALL serialise FIFO words MSB byte first; dout_vld SHALL pulse only when rdy=1 and dout_vld was 0 the previous cycle; -> IDLE after count*WB bytes.
REQ-017 din_vld in WREQ/WWAIT/RREQ/RDRAIN/ACK SHALL be ignored.
REQ-018 Timeout: in ADDR/CNT/WDATA, TIMEOUT cycles without din_vld SHALL flush the FIFO and -> IDLE; the counter SHALL reset on every din_vld.
REQ-019 Pop on empty and push on full SHALL be ignored; pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave the FIFO level unchanged.

Reset
REQ-021 rst high SHALL asynchronously force IDLE, FIFO empty, all counters 0, wr_req=rd_req=dout_vld=busy=0, dout=0, wr_addr=0, wr_cnt=0.
REQ-022 Reset mid-frame or mid-burst SHALL discard all partial state; no request pulse after release until a new complete frame.

Configuration
REQ-023 Macro UART_BRIDGE_ACK_EN defined: ACK state SHALL send byte 0x06 (obeying REQ-016 handshake) after wr_done, then -> IDLE.
REQ-024 Macro undefined: ACK state and logic SHALL be absent; WWAIT -> IDLE on wr_done; no TX bytes for writes.

Verification
REQ-025 Write frame A5 00 00 10 00 02 + 12 data bytes -> one wr_req, wr_addr=0x000010, wr_cnt=2, words popped in order.
REQ-026 Read frame 5A 00 00 10 00 02, controller returns 2 words -> one rd_req, 12 dout bytes MSB first, each only when rdy=1.
REQ-027 Count 0 and count DEPTH+1 -> no request, busy low, next valid frame accepted.
REQ-028 TIMEOUT=50, stop bytes mid-WDATA -> IDLE at 50 idle cycles, FIFO empty.
REQ-029 UART_BRIDGE_ACK_EN defined, write then wr_done -> single 0x06 on dout; undefined -> no dout_vld.
REQ-030 rst asserted during RDRAIN -> outputs at reset values immediately, no further dout_vld.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - UART byte-frame to memory burst bridge; define UART_BRIDGE_ACK_EN to send a 0x06 ack after each write burst
module uart_mem_bridge #(
  parameter int DATA_W  = 48,
  parameter int ADDR_W  = 23,
  parameter int CNT_W   = 9,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_vld,
  output logic              wr_req,
  output logic              rd_req,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_rd,
  input  logic              wr_done,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_vld,
  input  logic              rdy,
  output logic [7:0]        dout,
  output logic              dout_vld,
  output logic              busy
);

  localparam int WB = DATA_W / 8;
  localparam int AB = (ADDR_W + 7) / 8;
  localparam int CB = (CNT_W + 7) / 8;
  localparam int PW = $clog2(DEPTH);
  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;

  typedef enum logic [3:0] {
    IDLE, ADDR, CNT, WDATA, WREQ, WWAIT, RREQ, RDRAIN
`ifdef UART_BRIDGE_ACK_EN
    , ACK
`endif
  } state_t;

  state_t            state, state_nx;
  logic              is_wr;
  logic [DATA_W-1:0] word_sh;
  logic [7:0]        byte_idx;
  logic [CNT_W-1:0]  word_idx;
  logic [31:0]       to_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       level;

  logic              adv, lastb, push, pop, tx_fire;
  logic [DATA_W-1:0] push_data;
  logic [7:0]        tx_byte;
  logic [CNT_W-1:0]  cnt_in;
  logic              in_frame, timeout_hit, flush;
  logic              fifo_empty, fifo_full, do_push, do_pop;

  assign wr_req      = (state == WREQ);
  assign rd_req      = (state == RREQ);
  assign busy        = (state != IDLE);
  assign wr_data     = mem[rptr];
  assign cnt_in      = CNT_W'({wr_cnt, din});
  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == (PW+1)'(DEPTH));
  assign in_frame    = (state == ADDR) || (state == CNT) || (state == WDATA);
  assign timeout_hit = (TIMEOUT != 0) && in_frame && !din_vld && (to_cnt == 32'(TIMEOUT - 1));
  assign flush       = (state == IDLE) || timeout_hit;
  assign do_push     = push && !fifo_full;
  assign do_pop      = pop && !fifo_empty;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state decode plus the byte/word strobes and FIFO push/pop requests
  always_comb begin
    state_nx  = state;
    adv       = 1'b0;
    lastb     = 1'b0;
    push      = 1'b0;
    push_data = rd_data;
    pop       = 1'b0;
    tx_fire   = 1'b0;
    tx_byte   = 8'(wr_data >> {8'(WB - 1) - byte_idx, 3'b000});
    case (state)
      IDLE: if (din_vld && (din == CMD_WR || din == CMD_RD)) state_nx = ADDR;
      ADDR: if (din_vld) begin
        adv   = 1'b1;
        lastb = (byte_idx == 8'(AB - 1));
        if (lastb) state_nx = CNT;
      end
      CNT: if (din_vld) begin
        adv   = 1'b1;
        lastb = (byte_idx == 8'(CB - 1));
        if (lastb) begin
          if (cnt_in == '0 || 32'(cnt_in) > 32'(DEPTH)) state_nx = IDLE;
          else if (is_wr)                                state_nx = WDATA;
          else                                           state_nx = RREQ;
        end
      end
      WDATA: if (din_vld) begin
        adv   = 1'b1;
        lastb = (byte_idx == 8'(WB - 1));
        if (lastb) begin
          push      = 1'b1;
          push_data = DATA_W'({word_sh, din});
          if (word_idx == wr_cnt - CNT_W'(1)) state_nx = WREQ;
        end
      end
      WREQ: state_nx = WWAIT;
      WWAIT: begin
        pop = wr_data_rd;
        if (wr_done) begin
`ifdef UART_BRIDGE_ACK_EN
          state_nx = ACK;
`else
          state_nx = IDLE;
`endif
        end
      end
      RREQ: begin
        push     = rd_vld;
        state_nx = RDRAIN;
      end
      RDRAIN: begin
        push = rd_vld;
        // one byte per rdy window; the registered dout_vld enforces a gap cycle
        if (rdy && !dout_vld && !fifo_empty) begin
          tx_fire = 1'b1;
          adv     = 1'b1;
          lastb   = (byte_idx == 8'(WB - 1));
          if (lastb) begin
            pop = 1'b1;
            if (word_idx == wr_cnt - CNT_W'(1)) state_nx = IDLE;
          end
        end
      end
`ifdef UART_BRIDGE_ACK_EN
      ACK: if (rdy && !dout_vld) begin
        tx_fire  = 1'b1;
        tx_byte  = 8'h06;
        state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
    if (timeout_hit) state_nx = IDLE;
  end

  // frame fields, byte/word counters, idle timer and TX byte register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr    <= 1'b0;
      wr_addr  <= '0;
      wr_cnt   <= '0;
      word_sh  <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      to_cnt   <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= tx_fire;
      if (tx_fire) dout <= tx_byte;
      if (state == IDLE && din_vld && (din == CMD_WR || din == CMD_RD)) is_wr <= (din == CMD_WR);
      if (state == ADDR && din_vld)  wr_addr <= ADDR_W'({wr_addr, din});
      if (state == CNT && din_vld)   wr_cnt  <= cnt_in;
      if (state == WDATA && din_vld) word_sh <= DATA_W'({word_sh, din});
      if (state != state_nx || (adv && lastb)) byte_idx <= '0;
      else if (adv)                            byte_idx <= byte_idx + 8'd1;
      if (state != state_nx)   word_idx <= '0;
      else if (adv && lastb)   word_idx <= word_idx + CNT_W'(1);
      to_cnt <= (in_frame && !din_vld) ? to_cnt + 32'd1 : 32'd0;
    end
  end

  // FIFO pointers and level; emptied whenever the bridge is idle or a frame times out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      level <= level + (PW+1)'(1);
      else if (do_pop && !do_push) level <= level - (PW+1)'(1);
    end
  end

  // FIFO storage, no reset needed since the level gates every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - directed self-checking bench for uart_mem_bridge
module tb_uart_mem_bridge;
  localparam int DATA_W  = 48;
  localparam int ADDR_W  = 23;
  localparam int CNT_W   = 9;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50;

  logic              clk, rst;
  logic [7:0]        din;
  logic              din_vld;
  logic              wr_req, rd_req;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              wr_data_rd, wr_done, rd_vld, rdy;
  logic [7:0]        dout;
  logic              dout_vld, busy;

  int n_checks = 0;
  int n_err    = 0;
  int n_wr_req = 0;
  int n_rd_req = 0;
  int n_rdy_viol = 0;
  int n_dv_viol  = 0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [CNT_W-1:0]  cap_cnt  = '0;
  logic prev_rdy = 1'b0;
  logic prev_dv  = 1'b0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_rd [12] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6,
                              8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};

  uart_mem_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .wr_req(wr_req), .rd_req(rd_req), .wr_cnt(wr_cnt), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd), .wr_done(wr_done),
    .rd_data(rd_data), .rd_vld(rd_vld), .rdy(rdy),
    .dout(dout), .dout_vld(dout_vld), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  // request pulses, TX bytes and TX handshake rule observed mid-cycle
  always @(negedge clk) begin
    if (wr_req) begin
      n_wr_req++;
      cap_addr = wr_addr;
      cap_cnt  = wr_cnt;
    end
    if (rd_req) n_rd_req++;
    if (dout_vld) begin
      rx_q.push_back(dout);
      if (!prev_rdy) n_rdy_viol++;
      if (prev_dv)   n_dv_viol++;
    end
    prev_rdy = rdy;
    prev_dv  = dout_vld;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    din = b;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, input logic [15:0] c);
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic send_word(input logic [47:0] w);
    for (int i = 5; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic finish_write();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
`ifdef UART_BRIDGE_ACK_EN
    for (int i = 0; i < 20 && rx_q.size() == 0; i++) tick();
    tick();
    check("ack_count", rx_q.size(), 1);
    check("ack_byte", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'h06);
`else
    repeat (5) tick();
    check("no_ack_dout", rx_q.size(), 0);
`endif
    check("idle_after_write", busy, 1'b0);
    rx_q.delete();
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; wr_data_rd = 1'b0; wr_done = 1'b0;
    rd_data = '0; rd_vld = 1'b0; rdy = 1'b1;
    tick();
    tick();
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_dout_vld", dout_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_cnt", wr_cnt, '0);
    rst = 1'b0;
    tick();

    send_byte(8'h33);
    check("garbage_idle", busy, 1'b0);

    send_hdr(8'hA5, 24'h000010, 16'd2);
    send_word(48'h112233445566);
    send_word(48'h778899AABBCC);
    check("wr_req_count", n_wr_req, 1);
    check("wr_addr", cap_addr, 23'h000010);
    check("wr_cnt", cap_cnt, 9'd2);
    check("wwait_busy", busy, 1'b1);
    check("wr_word0", wr_data, 48'h112233445566);
    wr_data_rd = 1'b1;
    tick();
    check("wr_word1", wr_data, 48'h778899AABBCC);
    tick();
    wr_data_rd = 1'b0;
    finish_write();

    rdy = 1'b0;
    send_hdr(8'h5A, 24'h000010, 16'd2);
    check("rd_req_count", n_rd_req, 1);
    check("rd_addr", wr_addr, 23'h000010);
    check("rd_cnt", wr_cnt, 9'd2);
    rd_data = 48'hA1A2A3A4A5A6;
    rd_vld = 1'b1;
    tick();
    rd_data = 48'hB1B2B3B4B5B6;
    tick();
    rd_vld = 1'b0;
    repeat (4) tick();
    check("rdy_low_no_tx", rx_q.size(), 0);
    for (int i = 0; i < 300 && rx_q.size() < 12; i++) begin
      rdy = (i % 3 != 2);
      tick();
    end
    tick();
    check("rd_byte_count", rx_q.size(), 12);
    for (int i = 0; i < 12; i++) check("rd_byte", (i < rx_q.size()) ? rx_q[i] : 8'h00, exp_rd[i]);
    check("rdy_violations", n_rdy_viol, 0);
    check("dout_vld_back_to_back", n_dv_viol, 0);
    check("rd_done_idle", busy, 1'b0);
    rx_q.delete();
    rdy = 1'b1;

    send_hdr(8'hA5, 24'h000010, 16'd0);
    check("cnt0_no_req", n_wr_req, 1);
    check("cnt0_idle", busy, 1'b0);
    send_hdr(8'h5A, 24'h000010, 16'd17);
    tick();
    check("cnt17_no_req", n_rd_req, 1);
    check("cnt17_idle", busy, 1'b0);

    send_hdr(8'hA5, 24'hFFFFFF, 16'd1);
    send_word(48'hCAFEF00D1234);
    check("next_frame_req", n_wr_req, 2);
    check("addr_trunc", cap_addr, 23'h7FFFFF);
    check("cnt1", cap_cnt, 9'd1);
    check("cnt1_word", wr_data, 48'hCAFEF00D1234);
    wr_data_rd = 1'b1;
    tick();
    wr_data_rd = 1'b0;
    finish_write();

    send_hdr(8'hA5, 24'h000020, 16'd2);
    send_word(48'h010203040506);
    send_byte(8'h07);
    repeat (48) tick();
    check("timeout_not_early", busy, 1'b1);
    tick();
    check("timeout_fire", busy, 1'b0);
    check("timeout_no_req", n_wr_req, 2);
    send_hdr(8'hA5, 24'h000030, 16'd1);
    send_word(48'hDEADBEEF0123);
    check("post_timeout_req", n_wr_req, 3);
    check("fifo_flushed", wr_data, 48'hDEADBEEF0123);
    wr_data_rd = 1'b1;
    tick();
    wr_data_rd = 1'b0;
    finish_write();

    rdy = 1'b0;
    send_hdr(8'h5A, 24'h000040, 16'd2);
    rd_data = 48'hC1C2C3C4C5C6;
    rd_vld = 1'b1;
    tick();
    rd_data = 48'hD1D2D3D4D5D6;
    tick();
    rd_vld = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    check("pre_rst_dout_vld", dout_vld, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_dout_vld", dout_vld, 1'b0);
    check("arst_dout", dout, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_rd_req", rd_req, 1'b0);
    check("arst_wr_addr", wr_addr, '0);
    check("arst_wr_cnt", wr_cnt, '0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("post_rst_tx_count", rx_q.size(), 1);
    check("post_rst_first_byte", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'hC1);
    check("post_rst_no_req", n_rd_req + n_wr_req, 5);
    check("post_rst_idle", busy, 1'b0);
    check("final_rdy_violations", n_rdy_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
